// File: rtl/cdb_writeback_arbiter.sv
// Write-back arbiter: five one-entry FU holding buffers serialised onto a
// single registered common data bus by a round-robin arbiter.
module cdb_writeback_arbiter #(
  parameter int DATA_WIDTH    = 6,
  parameter int NUM_FU        = 5,
  parameter int ROB_IDX_WIDTH = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [NUM_FU-1:0]                       fu_valid,
  output logic [NUM_FU-1:0]                       fu_ready,
  input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]       fu_pd_s,
  input  logic [NUM_FU-1:0][31:0]                 fu_pd_v,
  input  logic [NUM_FU-1:0][ROB_IDX_WIDTH-1:0]    fu_rob_idx,
  output logic                                    cdb_valid,
  output logic [DATA_WIDTH-1:0]                   cdb_pd_s,
  output logic [31:0]                             cdb_pd_v,
  output logic [ROB_IDX_WIDTH-1:0]                cdb_rob_idx,
  output logic                                    regf_we
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [PTR_W:0] NUM_FU_X = (PTR_W+1)'(NUM_FU);

  // Reduce a pointer sum (always < 2*NUM_FU) back into 0..NUM_FU-1.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W:0] v);
    logic [PTR_W:0] r;
    if (v >= NUM_FU_X) begin
      r = v - NUM_FU_X;
    end else begin
      r = v;
    end
    return r[PTR_W-1:0];
  endfunction

  logic [NUM_FU-1:0]                    held_r;
  logic [NUM_FU-1:0][DATA_WIDTH-1:0]    buf_pd_s_r;
  logic [NUM_FU-1:0][31:0]              buf_pd_v_r;
  logic [NUM_FU-1:0][ROB_IDX_WIDTH-1:0] buf_rob_r;
  logic [PTR_W-1:0]                     rr_ptr_r;

  logic                                 cdb_valid_r;
  logic [DATA_WIDTH-1:0]                cdb_pd_s_r;
  logic [31:0]                          cdb_pd_v_r;
  logic [ROB_IDX_WIDTH-1:0]             cdb_rob_r;
  logic                                 regf_we_r;

  logic [NUM_FU-1:0]                    grant_s;
  logic                                 grant_any_s;
  logic [PTR_W-1:0]                     grant_idx_s;
  logic [PTR_W-1:0]                     cand_s;
  logic [NUM_FU-1:0]                    accept_s;

  // Round-robin pick: first held entry scanning upward from rr_ptr.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    grant_s     = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand_s = wrap_idx({1'b0, rr_ptr_r} + (PTR_W+1)'(k));
      if (!grant_any_s && held_r[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      grant_s[i] = grant_any_s && (grant_idx_s == PTR_W'(i));
    end
  end

  // A granted slot is free again in the same cycle; flush blocks all accepts.
  assign fu_ready = {NUM_FU{~flush}} & (~held_r | grant_s);
  assign accept_s = fu_valid & fu_ready;

  // Holding buffer payloads: captured on each accepted handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_pd_s_r <= '0;
      buf_pd_v_r <= '0;
      buf_rob_r  <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept_s[i]) begin
          buf_pd_s_r[i] <= fu_pd_s[i];
          buf_pd_v_r[i] <= fu_pd_v[i];
          buf_rob_r[i]  <= fu_rob_idx[i];
        end else begin
          buf_pd_s_r[i] <= buf_pd_s_r[i];
          buf_pd_v_r[i] <= buf_pd_v_r[i];
          buf_rob_r[i]  <= buf_rob_r[i];
        end
      end
    end
  end

  // Occupancy flags, round-robin pointer and the registered CDB broadcast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_r      <= '0;
      rr_ptr_r    <= '0;
      cdb_valid_r <= 1'b0;
      cdb_pd_s_r  <= '0;
      cdb_pd_v_r  <= 32'h0000_0000;
      cdb_rob_r   <= '0;
      regf_we_r   <= 1'b0;
    end else if (flush) begin
      held_r      <= '0;
      cdb_valid_r <= 1'b0;
      regf_we_r   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept_s[i]) begin
          held_r[i] <= 1'b1;
        end else if (grant_s[i]) begin
          held_r[i] <= 1'b0;
        end else begin
          held_r[i] <= held_r[i];
        end
      end
      if (grant_any_s) begin
        cdb_valid_r <= 1'b1;
        cdb_pd_s_r  <= buf_pd_s_r[grant_idx_s];
        cdb_pd_v_r  <= buf_pd_v_r[grant_idx_s];
        cdb_rob_r   <= buf_rob_r[grant_idx_s];
        // Writes to the zero register still complete in the ROB but never hit the regfile.
        regf_we_r   <= (buf_pd_s_r[grant_idx_s] != '0);
        rr_ptr_r    <= wrap_idx({1'b0, grant_idx_s} + {{PTR_W{1'b0}}, 1'b1});
      end else begin
        cdb_valid_r <= 1'b0;
        regf_we_r   <= 1'b0;
        rr_ptr_r    <= rr_ptr_r;
      end
    end
  end

  assign cdb_valid   = cdb_valid_r;
  assign cdb_pd_s    = cdb_pd_s_r;
  assign cdb_pd_v    = cdb_pd_v_r;
  assign cdb_rob_idx = cdb_rob_r;
  assign regf_we     = regf_we_r;

endmodule
